// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    RESP_NONE  = 3'd0,
    RESP_F     = 3'd1,
    RESP_M     = 3'd2,
    RESP_F_ERR = 3'd3,
    RESP_M_ERR = 3'd4
  } resp_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_F    = 2'd1;
  localparam logic [1:0] OWN_M    = 2'd2;

  localparam int DEF_MEM_DEPTH  = 2001;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive cycles the fetch port has been denied.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic grant,
  output logic at_max
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_r;

  // Count denied cycles; any grant or a dropped request starts over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (grant || !waiting) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r != MAX_C) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_max = (cnt_r == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch and data stages, data-priority with a
// one-cycle response pipe. MEM_ARB_STARVE_EN adds the fetch starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_error,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_gnt,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_error,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  resp_state_t       resp_st_r;
  resp_state_t       resp_nxt_s;
  logic              wr_r;
  logic [1:0]        owner_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              in_range_s;
  logic              f_prio_s;

`ifdef MEM_ARB_STARVE_EN
  logic at_max_s;

  mem_arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (f_req & ~f_gnt),
    .grant   (f_gnt),
    .at_max  (at_max_s)
  );

  assign f_prio_s = f_req & at_max_s;
`else
  assign f_prio_s = 1'b0;
`endif

  // Pick this cycle's owner; nothing is granted while reset is held.
  always_comb begin
    owner_s = OWN_NONE;
    if (!rst_n) begin
      owner_s = OWN_NONE;
    end else if (m_req && !f_prio_s) begin
      owner_s = OWN_M;
    end else if (f_req) begin
      owner_s = OWN_F;
    end else begin
      owner_s = OWN_NONE;
    end
  end

  assign sel_addr_s = (owner_s == OWN_M) ? m_addr : f_addr;
  assign in_range_s = (sel_addr_s < DEPTH_A);

  assign f_gnt = (owner_s == OWN_F);
  assign m_gnt = (owner_s == OWN_M);

  // Out-of-range accesses are granted but never reach the array.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if ((owner_s != OWN_NONE) && in_range_s) begin
      mem_en   = 1'b1;
      mem_addr = sel_addr_s;
      if ((owner_s == OWN_M) && m_we) begin
        mem_we    = 1'b1;
        mem_wdata = m_wdata;
      end else begin
        mem_we    = 1'b0;
        mem_wdata = {DATA_W{1'b0}};
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  // Response state follows the issued access one cycle later.
  always_comb begin
    resp_nxt_s = RESP_NONE;
    case (owner_s)
      OWN_F:   resp_nxt_s = in_range_s ? RESP_F : RESP_F_ERR;
      OWN_M:   resp_nxt_s = in_range_s ? RESP_M : RESP_M_ERR;
      default: resp_nxt_s = RESP_NONE;
    endcase
  end

  // Response tracker and write flag, updated unconditionally every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_st_r <= RESP_NONE;
      wr_r      <= 1'b0;
    end else begin
      resp_st_r <= resp_nxt_s;
      wr_r      <= (owner_s == OWN_M) && m_we;
    end
  end

  // Decode response pulses; write acks and errors return zero data.
  always_comb begin
    f_valid = 1'b0;
    f_error = 1'b0;
    f_rdata = {DATA_W{1'b0}};
    m_valid = 1'b0;
    m_error = 1'b0;
    m_rdata = {DATA_W{1'b0}};
    case (resp_st_r)
      RESP_F: begin
        f_valid = 1'b1;
        f_rdata = mem_rdata;
      end
      RESP_M: begin
        m_valid = 1'b1;
        m_rdata = wr_r ? {DATA_W{1'b0}} : mem_rdata;
      end
      RESP_F_ERR: begin
        f_valid = 1'b1;
        f_error = 1'b1;
      end
      RESP_M_ERR: begin
        m_valid = 1'b1;
        m_error = 1'b1;
      end
      default: begin
        f_valid = 1'b0;
        m_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a reference arbitration/memory model.
// Expectations follow MEM_ARB_STARVE_EN when the build defines it.
module tb_mem_port_arbiter;

  localparam int DEPTH = 2001;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0, m_req = 1'b0, m_we = 1'b0;
  logic [63:0] f_addr = 64'd0, m_addr = 64'd0, m_wdata = 64'd0;
  logic        f_gnt, f_valid, f_error, m_gnt, m_valid, m_error;
  logic [63:0] f_rdata, m_rdata;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata = 64'd0;

  logic [63:0] mem     [DEPTH];
  logic [63:0] ref_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
    .f_rdata(f_rdata), .f_error(f_error),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_valid(m_valid), .m_rdata(m_rdata), .m_error(m_error),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory array the DUT drives.
  always @(posedge clk) begin
    if (mem_en && (mem_addr < 64'd2001)) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Reference model: arbitration rules, starvation count, expected responses.
  int          starve = 0;
  logic        pf_valid = 1'b0, pf_err = 1'b0, pm_valid = 1'b0, pm_err = 1'b0;
  logic [63:0] pf_data = 64'd0, pm_data = 64'd0;

  always @(negedge clk) begin
    int          own;
    logic        inr;
    logic [63:0] a;
    if (!rst_n) begin
      chk("rst_f_valid", {63'd0, f_valid}, 64'd0);
      chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
      chk("rst_errors", {62'd0, f_error, m_error}, 64'd0);
      chk("rst_rdata", f_rdata | m_rdata, 64'd0);
      chk("rst_gnt", {62'd0, f_gnt, m_gnt}, 64'd0);
      chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
      starve = 0;
      pf_valid = 1'b0; pm_valid = 1'b0; pf_err = 1'b0; pm_err = 1'b0;
      pf_data = 64'd0; pm_data = 64'd0;
    end else begin
      chk("f_valid", {63'd0, f_valid}, {63'd0, pf_valid});
      chk("f_error", {63'd0, f_error}, {63'd0, pf_err});
      chk("f_rdata", f_rdata, pf_data);
      chk("m_valid", {63'd0, m_valid}, {63'd0, pm_valid});
      chk("m_error", {63'd0, m_error}, {63'd0, pm_err});
      chk("m_rdata", m_rdata, pm_data);
      // 0 none, 1 fetch, 2 data
      if (m_req && f_req) begin
`ifdef MEM_ARB_STARVE_EN
        own = (starve == SMAX) ? 1 : 2;
`else
        own = 2;
`endif
      end else if (m_req) own = 2;
      else if (f_req)     own = 1;
      else                own = 0;
      a   = (own == 2) ? m_addr : f_addr;
      inr = (own != 0) && (a < 64'd2001);
      chk("f_gnt", {63'd0, f_gnt}, {63'd0, own == 1});
      chk("m_gnt", {63'd0, m_gnt}, {63'd0, own == 2});
      chk("mem_en", {63'd0, mem_en}, {63'd0, inr});
      if (inr) begin
        chk("mem_we", {63'd0, mem_we}, {63'd0, (own == 2) && m_we});
        chk("mem_addr", mem_addr, a);
        chk("mem_wdata", mem_wdata, ((own == 2) && m_we) ? m_wdata : 64'd0);
      end else begin
        chk("idle_wdata", mem_wdata, 64'd0);
      end
      pf_valid = (own == 1);
      pf_err   = (own == 1) && !inr;
      pf_data  = ((own == 1) && inr) ? ref_mem[a] : 64'd0;
      pm_valid = (own == 2);
      pm_err   = (own == 2) && !inr;
      pm_data  = ((own == 2) && inr && !m_we) ? ref_mem[a] : 64'd0;
      if ((own == 2) && inr && m_we) ref_mem[a] = m_wdata;
      if (f_req && own != 1) starve = (starve < SMAX) ? starve + 1 : SMAX;
      else                   starve = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    f_req = 1'b0; m_req = 1'b0; m_we = 1'b0; m_wdata = 64'd0;
  endtask

  int fg_cnt;
  int mg_cnt;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = (64'(i) * 64'h0001_0001) ^ 64'hC0DE;
      ref_mem[i] = (64'(i) * 64'h0001_0001) ^ 64'hC0DE;
    end
    mem[10]     = 64'hA5;
    ref_mem[10] = 64'hA5;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Fetch-only read of a preloaded word.
    step(); f_req = 1'b1; f_addr = 64'd10;
    @(negedge clk); chk("lit_f_gnt", {63'd0, f_gnt}, 64'd1);
    step(); idle();
    @(negedge clk); chk("lit_f_valid", {63'd0, f_valid}, 64'd1);
    chk("lit_f_rdata", f_rdata, 64'hA5);

    // Write then read back.
    step(); m_req = 1'b1; m_we = 1'b1; m_addr = 64'd7; m_wdata = 64'h1234;
    step(); m_we = 1'b0; m_wdata = 64'd0;
    @(negedge clk); chk("lit_wr_valid", {63'd0, m_valid}, 64'd1);
    chk("lit_wr_rdata", m_rdata, 64'd0);
    step(); idle();
    @(negedge clk); chk("lit_rd_rdata", m_rdata, 64'h1234);

    // Out-of-range read, write, and boundary read.
    step(); m_req = 1'b1; m_addr = 64'd2001;
    @(negedge clk); chk("lit_oor_mem_en", {63'd0, mem_en}, 64'd0);
    step(); m_we = 1'b1; m_wdata = 64'hFFFF;
    @(negedge clk); chk("lit_oor_error", {63'd0, m_error}, 64'd1);
    chk("lit_oor_rdata", m_rdata, 64'd0);
    step(); m_we = 1'b0; m_wdata = 64'd0; m_addr = 64'd2000;
    step(); idle();
    @(negedge clk); chk("lit_edge_error", {63'd0, m_error}, 64'd0);

    // Back-to-back fetches, then fetch out of range.
    for (int i = 1; i <= 3; i++) begin
      step(); f_req = 1'b1; f_addr = 64'(i);
    end
    step(); f_addr = 64'd5000;
    step(); idle();
    @(negedge clk); chk("lit_f_oor_error", {63'd0, f_error}, 64'd1);

    // Sustained contention.
    fg_cnt = 0; mg_cnt = 0;
    step(); f_req = 1'b1; f_addr = 64'd30; m_req = 1'b1; m_addr = 64'd20;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (f_gnt) fg_cnt++;
      if (m_gnt) mg_cnt++;
    end
`ifdef MEM_ARB_STARVE_EN
    chk("lit_contend_f", 64'(fg_cnt), 64'd2);
    chk("lit_contend_m", 64'(mg_cnt), 64'd8);
`else
    chk("lit_contend_f", 64'(fg_cnt), 64'd0);
    chk("lit_contend_m", 64'(mg_cnt), 64'd10);
`endif
    step(); idle();
    @(negedge clk);

    // Reset arriving while a read response is in flight.
    step(); m_req = 1'b1; m_addr = 64'd5;
    @(negedge clk); chk("lit_pre_rst_gnt", {63'd0, m_gnt}, 64'd1);
    step(); rst_n = 1'b0;
    @(negedge clk); chk("lit_rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("lit_rst_m_gnt", {63'd0, m_gnt}, 64'd0);
    step(); idle(); rst_n = 1'b1;
    @(negedge clk); chk("lit_post_rst_valid", {63'd0, m_valid}, 64'd0);
    step(); f_req = 1'b1; f_addr = 64'd10;
    step(); idle();
    @(negedge clk); chk("lit_post_rst_f_rdata", f_rdata, 64'hA5);
    step();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single-ported, synchronous unified memory shared by the pipeline's fetch stage (instruction reads) and memory stage (data reads/writes). Grants at most one access per cycle, with data priority and a starvation guard for fetch. Checks address range and returns read data or an error one cycle after grant. Sits between the F/M stages and the memory array; stage logic treats a low grant as a stall.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data word width
- MEM_DEPTH, 2001, number of words; valid addresses 0..MEM_DEPTH-1
- STARVE_MAX, 4, max consecutive cycles fetch may be denied while requesting (only with MEM_ARB_STARVE_EN)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request, held until granted
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch access issued this cycle (combinational)
- f_valid  out  1  fetch response pulse
- f_rdata  out  DATA_W  fetch read data, valid with f_valid
- f_error  out  1  fetch address out of range, valid with f_valid
- m_req  in  1  data request, held until granted
- m_we  in  1  1 = write, 0 = read
- m_addr  in  ADDR_W  data word address
- m_wdata  in  DATA_W  write data
- m_gnt  out  1  data access issued this cycle (combinational)
- m_valid  out  1  data response pulse (reads and writes)
- m_rdata  out  DATA_W  data read data; 0 for writes and errors
- m_error  out  1  data address out of range (maps to stat 2 downstream)
- mem_en, mem_we  out  1  memory command strobes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- Per cycle, one winner:
  - m_req only → data wins.
  - f_req only → fetch wins.
  - both → data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- Winner's gnt = 1; loser's gnt = 0 (stall).
- Out-of-range address (addr >= MEM_DEPTH):
  - gnt still asserted, but mem_en stays 0, so no write occurs.
  - Response carries error = 1, rdata = 0.
- In-range access: mem_en = 1; mem_we = m_we for data, 0 for fetch; mem_addr/mem_wdata come from the winner. mem_wdata = 0 when not writing.
- starve_cnt:
  - increments (saturating at STARVE_MAX) each cycle f_req=1 and f_gnt=0.
  - clears on f_gnt or when f_req=0.
- Response tracker FSM, register resp_st:
  - RESP_NONE, RESP_F, RESP_M, RESP_F_ERR, RESP_M_ERR.
  - Next state is set by the cycle's winner and range check; RESP_NONE if no grant.
  - Transitions are unconditional every cycle, so issue and response overlap: throughput is one access per cycle.
- Response outputs decode resp_st:
  - RESP_F → f_valid=1, f_rdata=mem_rdata.
  - RESP_M → m_valid=1, m_rdata = mem_rdata for reads (0 for writes).
  - *_ERR states → valid=1, error=1, rdata=0.
- A registered flag records whether the data access was a write, so write acks return rdata 0.

## Timing
- Grant latency 0: gnt combinational from req/addr/state in cycle N.
- Response latency 1: valid/rdata/error in cycle N+1, exactly one-cycle pulse.
- Back-to-back grants to the same requester allowed every cycle.
- Reset (rst_n=0, any time):
  - resp_st=RESP_NONE, starve_cnt=0, write flag=0.
  - All valid/error outputs 0, rdata outputs 0.
  - gnt and mem_en forced 0 while rst_n=0.
  - An in-flight response is dropped.
- First grant possible in the first cycle after rst_n rises.

## Configuration
- MEM_ARB_STARVE_EN defined: starvation counter and fetch-priority override present, as above.
- MEM_ARB_STARVE_EN undefined: strict data priority, fetch granted only when m_req=0. No counter logic; STARVE_MAX unused.

## Structure
- Package mem_arb_pkg:
  - enum resp_state_t (the five response states).
  - Owner encoding localparams OWN_NONE/OWN_F/OWN_M.
  - Default MEM_DEPTH and STARVE_MAX constants.
- One sub-module, mem_arb_starve_cnt: saturating counter with inputs wait/grant, output at_max. Instantiated only under MEM_ARB_STARVE_EN.

## Test plan
- Reset mid-read: m_req read addr 5 granted, rst_n low next cycle → m_valid stays 0, all outputs 0.
- Fetch only, addr 10 holding 64'hA5: f_gnt same cycle, f_valid=1 with f_rdata=64'hA5 next cycle.
- Write then read:
  - m_we=1, addr 7, wdata 64'h1234 → m_valid=1, m_rdata=0.
  - Then read addr 7 → m_rdata=64'h1234.
- Out of range: m_req read addr 2001 → mem_en=0, next cycle m_valid=1, m_error=1, m_rdata=0. Write to 2001 leaves memory unchanged.
- Contention, STARVE_MAX=4, f_req and m_req held high:
  - with MEM_ARB_STARVE_EN: m_gnt for cycles 0–3, f_gnt in cycle 4, counter cleared, pattern repeats.
  - without MEM_ARB_STARVE_EN: f_gnt never asserts.
